// File: rtl/reg_file_mp.sv
// Multi-port register file with write-through read bypass, an a0 observation tap
// and a ready/valid serial dump engine that streams every register in index order.
//
// state    | meaning
// ST_IDLE  | no dump in progress, waiting for dump_start
// ST_SEND  | presenting reg[dump_idx], advancing on each accepted beat
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1,
    parameter int ZERO_R0 = 1,
    parameter int OBS_IDX = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]          a0,
    input  logic                       dump_start,
    output logic                       dump_busy,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [ADDR_W-1:0]          dump_idx,
    output logic [DATA_W-1:0]          dump_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0]          dump_data_q, dump_data_d;
    logic [DATA_W-1:0]          regs_q [0:DEPTH-1];
    logic [DATA_W-1:0]          regs_d [0:DEPTH-1];
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]          a0_q, a0_d;

    // regs_d is both the next stored state and the bypassed read view:
    // later ports overwrite earlier ones, so the highest write port wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_d[i*DATA_W +: DATA_W] = regs_d[rd_addr[i*ADDR_W +: ADDR_W]];
        end
        a0_d = regs_d[OBS_IDX];
    end

    always_comb begin
        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d    = ST_SEND;
                    dump_idx_d = '0;
                end
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (dump_idx_q == {ADDR_W{1'b1}}) begin
                        state_d    = ST_IDLE;
                        dump_idx_d = '0;
                    end else begin
                        dump_idx_d = dump_idx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dump_idx_d = '0;
            end
        endcase
        // Data tracks the index shown next cycle, so a write to a held index refreshes it.
        dump_data_d = regs_d[dump_idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            rd_data_q   <= '0;
            a0_q        <= '0;
            state_q     <= ST_IDLE;
            dump_idx_q  <= '0;
            dump_data_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
            rd_data_q   <= rd_data_d;
            a0_q        <= a0_d;
            state_q     <= state_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign a0         = a0_q;
    assign dump_busy  = (state_q == ST_SEND);
    assign dump_valid = (state_q == ST_SEND);
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (two write ports): an array-based model of the register
// file and dump sequence, checked every cycle, plus literal spot checks.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR*DW-1:0]    rd_data;
    logic [NW-1:0]       wr_en;
    logic [NW*AW-1:0]    wr_addr;
    logic [NW*DW-1:0]    wr_data;
    logic [DW-1:0]       a0;
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic                dump_ready;
    logic [AW-1:0]       dump_idx;
    logic [DW-1:0]       dump_data;

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_R0(1), .OBS_IDX(10)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .a0(a0),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];
    logic        m_busy;
    logic [4:0]  m_idx;
    int          beat_cnt;
    bit          log_beats;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Value a read of idx sees this cycle: last enabled write port to idx, else stored.
    function automatic logic [31:0] eff(input int idx);
        logic [31:0] v;
        if (idx == 0) return 32'h0;
        v = model[idx];
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == idx) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    task automatic step();
        logic [31:0] e_rd [NR];
        logic [31:0] e_a0, e_data;
        logic        nb;
        logic [4:0]  ni;
        for (int i = 0; i < NR; i++) e_rd[i] = eff(int'(rd_addr[i*AW +: AW]));
        e_a0 = eff(10);
        nb = m_busy;
        ni = m_idx;
        if (!m_busy) begin
            if (dump_start) begin nb = 1'b1; ni = 5'd0; end
        end else if (dump_ready) begin
            if (m_idx == 5'd31) begin nb = 1'b0; ni = 5'd0; end
            else ni = m_idx + 5'd1;
        end
        e_data = eff(int'(ni));
        if (log_beats && dump_valid && dump_ready) begin
            chk("beat_idx", 64'(dump_idx), 64'(beat_cnt));
            chk("beat_data", 64'(dump_data), 64'(beat_cnt * 3));
            beat_cnt++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++)
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(e_rd[i]));
        chk("a0", 64'(a0), 64'(e_a0));
        chk("dump_busy", 64'(dump_busy), 64'(nb));
        chk("dump_valid", 64'(dump_valid), 64'(nb));
        chk("dump_idx", 64'(dump_idx), 64'(ni));
        chk("dump_data", 64'(dump_data), 64'(e_data));
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != 5'd0)
                model[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
        m_busy = nb;
        m_idx  = ni;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd0"}, 64'(rd_data[31:0]), 64'h0);
        chk({tag, "_rd1"}, 64'(rd_data[63:32]), 64'h0);
        chk({tag, "_a0"}, 64'(a0), 64'h0);
        chk({tag, "_valid"}, 64'(dump_valid), 64'h0);
        chk({tag, "_busy"}, 64'(dump_busy), 64'h0);
        chk({tag, "_idx"}, 64'(dump_idx), 64'h0);
        chk({tag, "_data"}, 64'(dump_data), 64'h0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        m_busy = 1'b0;
        m_idx  = 5'd0;
        repeat (cycles) begin
            @(posedge clk); #1;
            check_reset_outputs("rst_held");
        end
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] addr, input logic [31:0] data);
        wr_en[port]            = 1'b1;
        wr_addr[port*AW +: AW] = addr;
        wr_data[port*DW +: DW] = data;
    endtask

    task automatic randomize_inputs();
        logic [4:0] wa0;
        wa0 = 5'($urandom_range(0, 31));
        wr_en = 2'($urandom_range(0, 3));
        wr_addr[4:0] = wa0;
        wr_addr[9:5] = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
        wr_data = {$urandom(), $urandom()};
        rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
        rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? wr_addr[9:5] : 5'($urandom_range(0, 31));
        dump_start = ($urandom_range(0, 15) == 0);
        dump_ready = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        log_beats = 1'b0;
        beat_cnt  = 0;
        idle_inputs();
        do_reset(2);

        // Reset in the middle of traffic; a prior write to x5 must not survive.
        wr(0, 5'd5, 32'h0000ABCD);
        step();
        repeat (8) begin randomize_inputs(); dump_start = 1'b0; step(); end
        do_reset(2);
        idle_inputs();
        rd_addr[4:0] = 5'd5;
        step();
        chk("t1_x5_after_rst", 64'(rd_data[31:0]), 64'h0);

        // Write then read next cycle, and same-cycle bypass.
        idle_inputs();
        wr(0, 5'd5, 32'hDEADBEEF);
        step();
        idle_inputs();
        rd_addr[4:0] = 5'd5;
        step();
        chk("t2_read_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        idle_inputs();
        wr(0, 5'd7, 32'h00001234);
        rd_addr[9:5] = 5'd7;
        step();
        chk("t2_bypass_x7", 64'(rd_data[63:32]), 64'h1234);

        // Zero register and write-port priority.
        idle_inputs();
        wr(0, 5'd0, 32'hFFFFFFFF);
        step();
        idle_inputs();
        step();
        chk("t3_x0_zero", 64'(rd_data[31:0]), 64'h0);
        wr(0, 5'd3, 32'h11);
        wr(1, 5'd3, 32'h22);
        rd_addr[9:5] = 5'd3;
        step();
        chk("t3_prio_bypass", 64'(rd_data[63:32]), 64'h22);
        idle_inputs();
        rd_addr[4:0] = 5'd3;
        step();
        chk("t3_prio_stored", 64'(rd_data[31:0]), 64'h22);

        // a0 mirror of x10.
        idle_inputs();
        wr(0, 5'd10, 32'h55);
        step();
        chk("t4_a0", 64'(a0), 64'h55);

        // Full dump of reg[i]=i*3 with ready toggling and a stray restart.
        for (int i = 0; i < 32; i += 2) begin
            idle_inputs();
            wr(0, 5'(i), 32'(i * 3));
            wr(1, 5'(i + 1), 32'((i + 1) * 3));
            step();
        end
        idle_inputs();
        log_beats  = 1'b1;
        beat_cnt   = 0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 200 && beat_cnt < 32; c++) begin
            dump_ready = (c % 2 == 0);
            dump_start = (c == 10);
            step();
        end
        log_beats = 1'b0;
        chk("t5_beats", 64'(beat_cnt), 64'd32);
        chk("t5_busy_drop", 64'(dump_busy), 64'h0);

        // Reset partway through a dump, then restart from index 0.
        idle_inputs();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 50 && dump_idx != 5'd12; c++) step();
        chk("t6_reach12", 64'(dump_idx), 64'd12);
        do_reset(1);
        idle_inputs();
        dump_start = 1'b1;
        step();
        chk("t6_restart_idx", 64'(dump_idx), 64'h0);
        chk("t6_restart_valid", 64'(dump_valid), 64'h1);

        // Randomized traffic including dumps.
        repeat (600) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
